svm_cfg_arbiter: RTL and testbench

- Shares the single SVM core configuration register port between NUM_REQ requesters: host loader (req 0) and the core sequencer/batch controller (req 1).
- Arbitrates round-robin and serializes one transaction at a time onto the cfg bus (cfg_req_vld / cfg_data_rb_w / cfg_addr / cfg_data).
- Waits for read data, then returns a per-requester response.
- Enforces address range checking, post-configuration write lock and read timeout.

---
 rtl/svm_cfg_arbiter.sv | 157 +++++++++++++++
 tb/tb_svm_cfg_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/svm_cfg_arbiter.sv
// Round-robin arbiter sharing the SVM core configuration register port between
// requesters; one transaction in flight, with range check, write lock and read timeout.
module svm_cfg_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int NUM_REGS      = 16,
    parameter int CFG_DONE_ADDR = 9,
    parameter int RD_TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_vld,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [16*NUM_REQ-1:0] req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_rdy,
    output logic [NUM_REQ-1:0]    rsp_vld,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic                  cfg_req_vld,
    output logic                  cfg_data_rb_w,
    output logic [15:0]           cfg_addr,
    output logic [31:0]           cfg_data,
    input  logic                  cfg_data_rd_vld,
    input  logic [31:0]           cfg_rd_data,
    input  logic                  cfg_done,
    output logic                  busy
);

    localparam int          PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          CNT_W       = $clog2(RD_TIMEOUT + 1);
    localparam logic [16:0] NUM_REGS_W  = 17'(NUM_REGS);
    localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;

    if (CFG_DONE_ADDR >= NUM_REGS || NUM_REQ < 1 || RD_TIMEOUT < 1) begin : g_bad_param
        $error("svm_cfg_arbiter: inconsistent parameters");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   owner;
    logic               gnt_found;
    logic               handshake;
    logic               sel_wr;
    logic [15:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic               cap_err;
    logic               own_wr;
    logic [CNT_W-1:0]   rd_cnt;
    logic               rd_timeout;

    // First valid requester at or after rr_ptr, wrapping around
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_found && req_vld[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
    end

    assign handshake  = (state == IDLE) && gnt_found;
    assign sel_wr     = req_wr[gnt_idx];
    assign sel_addr   = req_addr[16*gnt_idx +: 16];
    assign sel_wdata  = req_wdata[32*gnt_idx +: 32];
    // cfg_done is only consulted here; a later rise does not cancel a captured write
    assign cap_err    = ({1'b0, sel_addr} >= NUM_REGS_W) || (sel_wr && cfg_done);
    assign rd_timeout = (rd_cnt == CNT_W'(RD_TIMEOUT - 1));

    assign cfg_req_vld = (state == ISSUE);
    assign busy        = (state != IDLE);

    always_comb begin
        req_rdy = '0;
        if (handshake)
            req_rdy[gnt_idx] = 1'b1;
    end

    always_comb begin
        rsp_vld = '0;
        if (state == RESP)
            rsp_vld[owner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = cap_err ? RESP : ISSUE;
            ISSUE:   state_nxt = own_wr ? RESP : WAIT_RD;
            WAIT_RD: if (cfg_data_rd_vld || rd_timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            own_wr        <= 1'b0;
            rd_cnt        <= '0;
            cfg_data_rb_w <= 1'b0;
            cfg_addr      <= '0;
            cfg_data      <= '0;
            rsp_err       <= 1'b0;
            rsp_rdata     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        owner  <= gnt_idx;
                        own_wr <= sel_wr;
                        rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                        if (cap_err) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= ERR_PATTERN;
                        end else begin
                            // Downstream fields stay put until the next accepted access
                            cfg_data_rb_w <= sel_wr;
                            cfg_addr      <= sel_addr;
                            cfg_data      <= sel_wdata;
                        end
                    end
                end
                ISSUE: begin
                    rd_cnt <= '0;
                    if (own_wr) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                WAIT_RD: begin
                    if (cfg_data_rd_vld) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= cfg_rd_data;
                    end else if (rd_timeout) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= ERR_PATTERN;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_svm_cfg_arbiter.sv
// Directed and randomized bench for svm_cfg_arbiter; expected responses come from
// the latency/error rules of the arbiter applied per transaction.
module tb_svm_cfg_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int NUM_REGS   = 16;
    localparam int RD_TIMEOUT = 15;
    localparam int MAXK       = 24;
    localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_vld;
    logic [NUM_REQ-1:0]    req_wr;
    logic [16*NUM_REQ-1:0] req_addr;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_rdy;
    logic [NUM_REQ-1:0]    rsp_vld;
    logic                  rsp_err;
    logic [31:0]           rsp_rdata;
    logic                  cfg_req_vld;
    logic                  cfg_data_rb_w;
    logic [15:0]           cfg_addr;
    logic [31:0]           cfg_data;
    logic                  cfg_data_rd_vld;
    logic [31:0]           cfg_rd_data;
    logic                  cfg_done;
    logic                  busy;

    int total  = 0;
    int passes = 0;

    svm_cfg_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .CFG_DONE_ADDR(9), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .cfg_req_vld(cfg_req_vld), .cfg_data_rb_w(cfg_data_rb_w), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_data_rd_vld(cfg_data_rd_vld), .cfg_rd_data(cfg_rd_data),
        .cfg_done(cfg_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One transaction from a lone requester. d = cycles from ISSUE+1 until rd_vld (<0: never).
    // Cycle k counts from the handshake cycle (k=0).
    task automatic run_txn(input int r, input logic wr, input logic [15:0] addr,
                           input logic [31:0] wd, input logic done, input int d,
                           input logic [31:0] rdd);
        logic        exp_issue, exp_err;
        int          exp_k;
        logic [31:0] exp_rdata;
        int          n_iss, iss_k, n_rsp, rsp_k;
        logic        iss_rbw, got_err;
        logic [15:0] iss_addr;
        logic [31:0] iss_data, got_rdata;
        logic [NUM_REQ-1:0] got_vld;

        exp_issue = !((addr >= NUM_REGS) || (wr && done));
        if (!exp_issue) begin
            exp_k = 1; exp_err = 1'b1; exp_rdata = ERR_PATTERN;
        end else if (wr) begin
            exp_k = 2; exp_err = 1'b0; exp_rdata = 32'h0;
        end else if (d >= 0 && d < RD_TIMEOUT) begin
            exp_k = 3 + d; exp_err = 1'b0; exp_rdata = rdd;
        end else begin
            exp_k = 2 + RD_TIMEOUT; exp_err = 1'b1; exp_rdata = ERR_PATTERN;
        end

        n_iss = 0; iss_k = -1; n_rsp = 0; rsp_k = -1;
        iss_rbw = 1'b0; iss_addr = '0; iss_data = '0;
        got_err = 1'b0; got_rdata = '0; got_vld = '0;

        req_vld = '0;
        req_vld[r] = 1'b1;
        req_wr[r] = wr;
        req_addr[16*r +: 16] = addr;
        req_wdata[32*r +: 32] = wd;
        cfg_done = done;
        #1 chk("req_rdy", 64'(req_rdy), 64'(1 << r));

        for (int k = 1; k <= MAXK; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_vld = '0;
                cfg_done = 1'($urandom_range(0, 1));
            end
            if (cfg_req_vld) begin
                n_iss++; iss_k = k;
                iss_rbw = cfg_data_rb_w; iss_addr = cfg_addr; iss_data = cfg_data;
            end
            if (rsp_vld != '0) begin
                n_rsp++; rsp_k = k;
                got_vld = rsp_vld; got_err = rsp_err; got_rdata = rsp_rdata;
            end
            cfg_data_rd_vld = (d >= 0) && (k == 2 + d);
            cfg_rd_data = cfg_data_rd_vld ? rdd : $urandom;
        end
        cfg_data_rd_vld = 1'b0;

        chk("issue_count", 64'(n_iss), 64'(exp_issue));
        if (exp_issue) begin
            chk("issue_cycle", 64'(iss_k), 64'd1);
            chk("issue_fields", {15'd0, iss_rbw, iss_addr, iss_data}, {15'd0, wr, addr, wd});
        end
        chk("rsp_count", 64'(n_rsp), 64'd1);
        chk("rsp_cycle", 64'(rsp_k), 64'(exp_k));
        chk("rsp_owner", 64'(got_vld), 64'(1 << r));
        chk("rsp_err", 64'(got_err), 64'(exp_err));
        chk("rsp_rdata", 64'(got_rdata), 64'(exp_rdata));
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ctl"}, 64'({req_rdy, rsp_vld, rsp_err, cfg_req_vld, cfg_data_rb_w, busy}), 64'd0);
        chk({tag, "_cfg"}, {cfg_addr, cfg_data}, 64'd0);
        chk({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
    endtask

    initial begin
        int gnt_q[$];
        int cyc_q[$];
        int n_stray;

        rst = 1'b1;
        req_vld = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        cfg_data_rd_vld = 1'b0; cfg_rd_data = '0; cfg_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check_outputs_zero("reset");
        @(negedge clk);

        // Host write, then sequencer read answered three cycles after ISSUE
        run_txn(0, 1'b1, 16'd6, 32'd2, 1'b0, -1, 32'd0);
        run_txn(1, 1'b0, 16'd7, 32'd0, 1'b0, 2, 32'd12);

        // Range error, write lock, and read allowed under lock
        run_txn(0, 1'b1, 16'd20, 32'h1234, 1'b0, -1, 32'd0);
        run_txn(1, 1'b1, 16'd3, 32'h55, 1'b1, -1, 32'd0);
        run_txn(0, 1'b0, 16'd3, 32'd0, 1'b1, 0, 32'hCAFE0003);

        // Timeout, with a late rd_vld afterwards; and rd_vld on the last allowed cycle
        run_txn(1, 1'b0, 16'd4, 32'd0, 1'b0, 18, 32'h11111111);
        run_txn(0, 1'b0, 16'd5, 32'd0, 1'b0, RD_TIMEOUT - 1, 32'h22222222);
        run_txn(1, 1'b0, 16'd5, 32'd0, 1'b0, RD_TIMEOUT, 32'h33333333);

        // Both requesters held from reset: alternating grants, one every three cycles
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_vld = 2'b11; req_wr = 2'b11; cfg_done = 1'b0;
        req_addr = {16'd2, 16'd1}; req_wdata = {32'hB, 32'hA};
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_rdy != '0) begin
                gnt_q.push_back(int'(req_rdy));
                cyc_q.push_back(c);
            end
            @(negedge clk);
        end
        req_vld = '0;
        chk("rr_grant_count", 64'(gnt_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < gnt_q.size(); i++) begin
            chk("rr_grant_owner", 64'(gnt_q[i]), 64'((i % 2 == 0) ? 1 : 2));
            chk("rr_grant_cycle", 64'(cyc_q[i]), 64'(3 * i));
        end
        repeat (2) @(negedge clk);

        // Reset while waiting for read data from requester 0
        req_vld = 2'b01; req_wr = 2'b00; req_addr[15:0] = 16'd5;
        @(negedge clk);
        req_vld = '0;
        repeat (2) @(negedge clk);
        chk("busy_in_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        #1 check_outputs_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        cfg_data_rd_vld = 1'b1; cfg_rd_data = 32'h55;
        n_stray = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cfg_data_rd_vld = 1'b0;
            if (rsp_vld != '0) n_stray++;
        end
        chk("no_rsp_after_reset", 64'(n_stray), 64'd0);
        req_vld = 2'b11;
        #1 chk("rr_ptr_reset", 64'(req_rdy), 64'd1);
        req_vld = '0;
        @(negedge clk);

        // Randomized single-requester transactions
        for (int i = 0; i < 25; i++) begin
            run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom_range(0, 21)), $urandom, ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 20)), $urandom);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
